// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver and the matching transmitter.
// Holds the deframing FSM state encoding, the idle line level and an
// even-parity helper usable for any word width up to MAX_DATA_W.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    // Level of the serial line between frames; a start bit is the opposite level.
    localparam logic IDLE_LEVEL = 1'b1;

    // Widest data word any user of this package may configure.
    localparam int MAX_DATA_W = 32;

    // Even-parity bit of the low 'width' bits of 'word': 1 when that slice
    // holds an odd number of ones, so data plus parity always has an even count.
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] word,
                                         input int unsigned           width);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if (i < width) p = p ^ word[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/serial_frame_fifo.sv
// Synchronous first-word-fall-through FIFO for received words.
// Pointers carry one extra MSB so full and empty are distinguishable.
// A push while full is accepted only when a pop happens in the same cycle.
// While empty, pop_data holds the last word that was popped (0 after reset).
module serial_frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             iccad_clk,
    input  logic             iccad_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             wr_fire;
    logic             rd_fire;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign rd_fire = pop && !empty;
    assign wr_fire = push && (!full || rd_fire);

    assign pop_data = empty ? last_q : mem[rd_ptr_q[PTR_W-1:0]];

    // Next pointer and last-popped-word values.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = mem[rd_ptr_q[PTR_W-1:0]];
        end
    end

    // Pointer and last-word registers.
    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (iccad_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
        end
    end

    // Word storage write port.
    always_ff @(posedge iccad_clk) begin
        // NOTE: storage is deliberately not reset; equal pointers mark it empty
        // and pop_data shows last_q then, so stale contents are never visible.
        if (wr_fire) mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: start bit, DATA_W data bits LSB first,
// optional even-parity bit, stop bit. Good words go into a small FIFO
// presented on a valid/ready interface; framing, parity and overflow errors
// are reported as registered one-cycle pulses and in a saturating counter.
// Optional feature macro: SERIAL_FRAME_RX_PARITY_EN (adds the parity bit).
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 iccad_clk,
    input  logic                 iccad_rst,
    input  logic                 inp,
    input  logic                 inp_en,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    import serial_frame_pkg::*;

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                frame_err_q, frame_err_d;
    logic                overflow_q, overflow_d;
    logic                push;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic                par_bad_q, par_bad_d;
    logic                parity_err_q, parity_err_d;
`endif

    // Deframing next-state logic; everything holds unless inp_en samples the line.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (inp_en) begin
            case (state_q)
                IDLE: begin
                    if (inp != IDLE_LEVEL) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                DATA: begin
                    shift_d[cnt_q] = inp;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                PARITY: begin
                    par_bad_d = (inp != even_parity(MAX_DATA_W'(shift_q), $unsigned(DATA_W)));
                    state_d   = STOP;
                end
`endif
                STOP: begin
                    // A low stop bit is a framing error, never a new start bit.
                    if (inp == IDLE_LEVEL) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        if (par_bad_q) parity_err_d = 1'b1;
                        else           push         = 1'b1;
`else
                        push = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A good word is dropped only when the FIFO is full and nothing leaves it this cycle.
    assign overflow_d = push && fifo_full && !out_ready;

    // FSM state, deframing registers and registered error pulses.
    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        if (iccad_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

    // Saturating error count; clear wins over a same-cycle increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if ((frame_err_q || parity_err || overflow_q) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        if (iccad_rst) err_cnt_q <= '0;
        else           err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;

    serial_frame_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iccad_clk (iccad_clk),
        .iccad_rst (iccad_rst),
        .push      (push),
        .push_data (shift_q),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx with default parameters
// (DATA_W=8, FIFO_DEPTH=4, ERR_CNT_W=8). Expected words are queued by the
// stimulus; a monitor pops and compares on every accepted output word.
module tb_serial_frame_rx;

    logic       iccad_clk;
    logic       iccad_rst;
    logic       inp;
    logic       inp_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overflow;
    logic [7:0] err_cnt;
    logic       err_clr;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_frame_pulses = 0;
    int         n_parity_pulses = 0;
    int         n_ovf_pulses = 0;
    logic [7:0] exp_q [$];

    serial_frame_rx #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .ERR_CNT_W  (8)
    ) dut (
        .iccad_clk  (iccad_clk),
        .iccad_rst  (iccad_rst),
        .inp        (inp),
        .inp_en     (inp_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow),
        .err_cnt    (err_cnt),
        .err_clr    (err_clr)
    );

    initial iccad_clk = 1'b0;
    always #5 iccad_clk = ~iccad_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted word against the scoreboard, count pulses.
    always @(negedge iccad_clk) begin
        if (!iccad_rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got 0x%0h, expected none (t=%0t)", out_data, $time);
                end else begin
                    check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (frame_err)  n_frame_pulses++;
            if (parity_err) n_parity_pulses++;
            if (overflow)   n_ovf_pulses++;
        end
    end

    // One line sample: gap idle-strobe cycles (line at the opposite level), then the bit.
    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            inp_en = 1'b0;
            inp    = ~b;
            @(posedge iccad_clk); #1;
        end
        inp_en = 1'b1;
        inp    = b;
        @(posedge iccad_clk); #1;
        inp_en = 1'b0;
        inp    = 1'b1;
    endtask

    // Full frame; returns 1ns after the stop-bit sampling edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              input int gap, input logic ready_at_stop);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_bit((^d) ^ par_flip, gap);
`else
        if (par_flip) $display("note: parity flip ignored without parity feature");
`endif
        if (ready_at_stop) out_ready = 1'b1;
        send_bit(stop_b, gap);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && (exp_q.size() != 0 || out_valid); i++) @(negedge iccad_clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        iccad_rst = 1'b1;
        inp       = 1'b1;
        inp_en    = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (3) @(posedge iccad_clk);
        #1 iccad_rst = 1'b0;
        @(negedge iccad_clk);

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_pulses", {frame_err, parity_err, overflow}, 0);
        @(posedge iccad_clk); #1;

        // Clean 0xA5, strobe every cycle: valid exactly one cycle after stop sample
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
        @(negedge iccad_clk);
        check("a5_latency_valid", out_valid, 1);
        check("a5_no_err", {frame_err, parity_err, overflow}, 0);
        drain("a5_drained");

        // Same frame, strobe every third cycle
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 2, 1'b0);
        @(negedge iccad_clk);
        check("a5_slow_valid", out_valid, 1);
        drain("a5_slow_drained");

        // 0x3C with low stop bit: one frame_err, no word, err_cnt=1
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
        @(negedge iccad_clk);
        check("ferr_pulse", frame_err, 1);
        check("ferr_no_push", out_valid, 0);
        @(negedge iccad_clk);
        check("ferr_one_cycle", frame_err, 0);
        check("ferr_err_cnt", err_cnt, 1);
        @(posedge iccad_clk); #1;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
        drain("after_ferr_drained");
        check("after_ferr_pulses", n_frame_pulses, 1);

        // Overflow: 5 frames into a 4-deep FIFO with consumer stalled
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back(8'(k));
            send_frame(8'(k), 1'b1, 1'b0, 0, 1'b0);
        end
        @(negedge iccad_clk);
        check("ovf_pulse", overflow, 1);
        check("ovf_stall_data", out_data, 8'h01);
        @(negedge iccad_clk);
        check("ovf_one_cycle", overflow, 0);
        check("ovf_err_cnt", err_cnt, 2);
        @(posedge iccad_clk); #1;
        // Push while full with a simultaneous pop is accepted
        send_frame(8'h06, 1'b1, 1'b0, 0, 1'b1);
        exp_q.push_back(8'h06);
        @(negedge iccad_clk);
        check("full_push_pop_no_ovf", overflow, 0);
        drain("ovf_drained");
        check("ovf_err_cnt_final", err_cnt, 2);

        // Reset in the middle of a frame with a word waiting and errors counted
        out_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0);
        send_bit(1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        iccad_rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_data", out_data, 0);
        @(posedge iccad_clk); #2;
        iccad_rst = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        repeat (3) @(negedge iccad_clk);
        check("midrst_no_word", out_valid, 0);
        out_ready = 1'b1;
        @(posedge iccad_clk); #1;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 1'b0, 0, 1'b0);
        drain("post_rst_drained");

`ifdef SERIAL_FRAME_RX_PARITY_EN
        // Parity: 0x07 has three ones, so the correct even-parity bit is 1
        send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0);
        @(negedge iccad_clk);
        check("par_err_pulse", parity_err, 1);
        check("par_err_no_push", out_valid, 0);
        @(negedge iccad_clk);
        check("par_err_cnt", err_cnt, 1);
        @(posedge iccad_clk); #1;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0, 0, 1'b0);
        drain("par_ok_drained");
        err_clr = 1'b1;
        @(posedge iccad_clk); #1;
        err_clr = 1'b0;
`endif

        // Saturation: 300 framing errors pin err_cnt at 255
        for (int k = 0; k < 300; k++) send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) @(negedge iccad_clk);
        check("sat_err_cnt", err_cnt, 255);
        @(posedge iccad_clk); #1;
        // Clear in the same cycle the next increment would land
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
        err_clr = 1'b1;
        @(posedge iccad_clk); #1;
        err_clr = 1'b0;
        @(negedge iccad_clk);
        check("clr_priority", err_cnt, 0);
        @(negedge iccad_clk);
        check("clr_stays", err_cnt, 0);
        @(posedge iccad_clk); #1;
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
        repeat (2) @(negedge iccad_clk);
        check("count_after_clr", err_cnt, 1);

        // Pulse totals over the whole run
        check("total_frame_pulses", n_frame_pulses, 303);
        check("total_ovf_pulses", n_ovf_pulses, 1);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        check("total_parity_pulses", n_parity_pulses, 1);
`else
        check("total_parity_pulses", n_parity_pulses, 0);
`endif
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Bit-serial frame receiver for the single-bit output of a gate-level core such as `simple`.
- Deframes start/data/stop bits into parallel words.
- Buffers received words in a small FIFO and presents them on a valid/ready interface.
- Reports framing, parity and overflow errors; sits between the netlist core under test and the word-level checker logic.

Parameters:
- DATA_W, 8: data bits per frame, LSB first; legal range 1..32.
- FIFO_DEPTH, 4: receive FIFO entries; must be a power of two, at least 2.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- iccad_clk  in  1  sole clock; all state on its rising edge.
- iccad_rst  in  1  asynchronous, active-high reset.
- inp  in  1  serial data line; idles at 1.
- inp_en  in  1  bit strobe; inp is sampled only in cycles where inp_en=1.
- out_data  out  DATA_W  head-of-FIFO word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid=1 and out_ready=1.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- parity_err  out  1  one-cycle pulse: parity mismatch (feature only; otherwise tied 0).
- overflow  out  1  one-cycle pulse: good frame dropped because FIFO full.
- err_cnt  out  ERR_CNT_W  saturating count of all error pulses.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (async assert):
  - FSM goes to IDLE; bit counter and shift register cleared.
  - FIFO emptied.
  - out_valid=0, out_data=0, all error pulses 0, err_cnt=0.
  - A frame in progress is discarded; no partial word is ever pushed.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions happen only on cycles with inp_en=1; with inp_en=0 all FSM state holds.
  - IDLE: inp=0 goes to DATA with bit count 0; inp=1 stays in IDLE.
  - DATA: shift inp into bit [count] (LSB first) and increment count. After bit DATA_W-1, go to PARITY if the feature is compiled in, else STOP.
  - PARITY: sample the parity bit, latch the mismatch, go to STOP.
  - STOP, inp=1 with no parity mismatch: push the word, then IDLE.
  - STOP, inp=1 with parity mismatch: parity_err pulse, word discarded, then IDLE.
  - STOP, inp=0: frame_err pulse, word discarded, then IDLE. This 0 is not treated as a new start bit.
- Latency: a pushed word appears on out_data with out_valid=1 in the cycle after the stop-bit sample.
- FIFO:
  - Push and pop in the same cycle are both honoured, so occupancy is unchanged.
  - Push when full without a simultaneous pop: word dropped and overflow pulses.
  - Push when full with a simultaneous pop: accepted, no overflow.
  - out_data must be stable while out_valid=1 and out_ready=0.
  - When empty, out_data holds its last value; consumers must not rely on it.
  - Read and write pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
- Error pulses:
  - All three error pulses are registered: high exactly one cycle, in the cycle after the causing sample.
- err_cnt:
  - Increments by the number of error pulses asserted in a cycle (at most 1 by construction).
  - Saturates at 2^ERR_CNT_W-1 and never wraps.
  - err_clr takes priority over an increment in the same cycle.

Optional Feature:
- Macro SERIAL_FRAME_RX_PARITY_EN.
- When defined:
  - An even-parity bit follows the data bits; the frame is 1+DATA_W+1+1 bits.
  - The PARITY state exists and parity_err is driven.
- When undefined:
  - The frame is 1+DATA_W+1 bits.
  - The PARITY state and its logic are absent; parity_err is tied 0.

Decomposition:
- Shared package serial_frame_pkg holds:
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - the constant IDLE_LEVEL=1;
  - a function computing the even-parity bit of a DATA_W word.
- The future matching transmitter uses the same package.
- One natural sub-module: serial_frame_fifo, a synchronous FIFO parameterised by width and depth with push, pop, full, empty, and reset on iccad_rst.

Test Plan:
- Clean frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), inp_en=1 every cycle, out_ready=1 -> out_valid one cycle after the stop sample, out_data=0xA5, no errors.
- Same frame with inp_en=1 only every 3rd cycle -> identical result; FSM holds on all cycles where inp_en=0.
- Frame 0x3C with stop bit 0 -> frame_err pulses exactly once, no push, err_cnt=1; FSM returns to IDLE and the next valid frame 0x11 is received correctly.
- out_ready=0 while 5 good frames 0x01..0x05 arrive (DEPTH=4) -> fifth frame raises overflow and is dropped. Then out_ready=1 drains 0x01..0x04 in order; push-during-pop-when-full is accepted without overflow.
- Assert iccad_rst midway through the data bits of a frame -> out_valid=0, FIFO empty, err_cnt=0 immediately; the remaining line bits create no word.
- With SERIAL_FRAME_RX_PARITY_EN: frame 0x07 with parity bit 0 -> parity_err pulse, no push. Same word with parity bit 1 -> out_data=0x07. Also force 300 errors -> err_cnt saturates at 255, then err_clr returns it to 0.
